spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter.sv | 254 +++++++++++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter
// Two read ports (fetch, data) share one SPI NOR flash. A round-robin
// arbiter grants one port in IDLE, then the sequencer issues a 0x03 READ
// (command + 24-bit address) in SPI mode 0 and clocks in one data byte.
// Optional build macro SEQ_READ_EN: chip select stays low between reads and
// a read at the tracked next address continues the open stream with only
// 8 SCLK periods (no command/address phase).
module spi_flash_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [11:0] f_addr,
   output logic        f_ack,
   input  logic        d_req,
   input  logic [11:0] d_addr,
   output logic        d_ack,
   output logic [7:0]  rdata,
   input  logic        fast,
   output logic        spi_cs_n,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CSHI  = 2'd1,
      SHIFT = 2'd2,
      ACK   = 2'd3
   } state_t;

`ifdef SEQ_READ_EN
   localparam logic SEQ_EN = 1'b1;
`else
   localparam logic SEQ_EN = 1'b0;
`endif

   // sequencer state and datapath registers
   state_t      r_state;
   logic [1:0]  r_ph;          // clk phase inside one SCLK period (also CSHI count)
   logic [5:0]  r_bit;         // SCLK periods remaining minus one
   logic [31:0] r_sh;          // outgoing command/address, MSB first
   logic [7:0]  r_rx;          // incoming bits from miso
   logic [11:0] r_addr;        // latched request address
   logic        r_port;        // 0 = fetch, 1 = data
   logic        r_fast;        // latched speed for the whole transaction
   logic        r_last;        // last served port (round-robin pointer)
   logic [11:0] r_next_addr;   // flash address following the last completed read
   logic        r_next_vld;

   // registered outputs
   logic        r_cs_n;
   logic        r_sclk;
   logic        r_mosi;
   logic        r_f_ack;
   logic        r_d_ack;
   logic [7:0]  r_rdata;

   // next values
   state_t      w_state_nxt;
   logic [1:0]  w_ph_nxt;
   logic [5:0]  w_bit_nxt;
   logic [31:0] w_sh_nxt;
   logic [7:0]  w_rx_nxt;
   logic [11:0] w_addr_nxt;
   logic        w_port_nxt;
   logic        w_fast_nxt;
   logic        w_last_nxt;
   logic [11:0] w_next_addr_nxt;
   logic        w_next_vld_nxt;
   logic        w_cs_n_nxt;
   logic        w_sclk_nxt;
   logic        w_mosi_nxt;
   logic        w_f_ack_nxt;
   logic        w_d_ack_nxt;
   logic [7:0]  w_rdata_nxt;
   logic        w_done;

   // arbitration and bit-timing decode
   logic        w_any_req;
   logic        w_gnt_port;
   logic [11:0] w_gnt_addr;
   logic        w_seq_hit;
   logic        w_sample;      // last low clk of SCLK: miso captured as SCLK rises
   logic        w_per_end;     // last clk of the SCLK period

   assign w_any_req  = f_req | d_req;
   assign w_gnt_port = (f_req & d_req) ? ~r_last : d_req;
   assign w_gnt_addr = w_gnt_port ? d_addr : f_addr;
   assign w_seq_hit  = SEQ_EN & r_next_vld & (w_gnt_addr == r_next_addr);
   assign w_sample   = r_fast ? (r_ph == 2'd0) : (r_ph == 2'd1);
   assign w_per_end  = r_fast ? (r_ph == 2'd1) : (r_ph == 2'd3);

   assign spi_cs_n = r_cs_n;
   assign spi_sclk = r_sclk;
   assign spi_mosi = r_mosi;
   assign f_ack    = r_f_ack;
   assign d_ack    = r_d_ack;
   assign rdata    = r_rdata;

   // state register and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ph        <= 2'd0;
         r_bit       <= 6'd0;
         r_sh        <= 32'h0000_0000;
         r_rx        <= 8'h00;
         r_addr      <= 12'h000;
         r_port      <= 1'b0;
         r_fast      <= 1'b0;
         r_last      <= 1'b1;
         r_next_addr <= 12'h000;
         r_next_vld  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_ph        <= w_ph_nxt;
         r_bit       <= w_bit_nxt;
         r_sh        <= w_sh_nxt;
         r_rx        <= w_rx_nxt;
         r_addr      <= w_addr_nxt;
         r_port      <= w_port_nxt;
         r_fast      <= w_fast_nxt;
         r_last      <= w_last_nxt;
         r_next_addr <= w_next_addr_nxt;
         r_next_vld  <= w_next_vld_nxt;
      end
   end

   // next-state logic: grant in IDLE, CS-high gap, shift 40 (or 8) periods, ack
   always_comb begin
      w_state_nxt     = r_state;
      w_ph_nxt        = r_ph;
      w_bit_nxt       = r_bit;
      w_sh_nxt        = r_sh;
      w_rx_nxt        = r_rx;
      w_addr_nxt      = r_addr;
      w_port_nxt      = r_port;
      w_fast_nxt      = r_fast;
      w_last_nxt      = r_last;
      w_next_addr_nxt = r_next_addr;
      w_next_vld_nxt  = r_next_vld;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_addr_nxt = w_gnt_addr;
               w_port_nxt = w_gnt_port;
               w_fast_nxt = fast;
               w_last_nxt = w_gnt_port;
               w_ph_nxt   = 2'd0;
               if (w_seq_hit) begin
                  w_state_nxt = SHIFT;
                  w_bit_nxt   = 6'd7;
                  w_sh_nxt    = 32'h0000_0000;
               end else begin
                  w_state_nxt = CSHI;
                  w_bit_nxt   = 6'd39;
                  w_sh_nxt    = {8'h03, 12'h000, w_gnt_addr};
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         CSHI: begin
            if (r_ph == 2'd1) begin
               w_state_nxt = SHIFT;
               w_ph_nxt    = 2'd0;
            end else begin
               w_ph_nxt = r_ph + 2'd1;
            end
         end
         SHIFT: begin
            if (w_sample) begin
               w_rx_nxt = {r_rx[6:0], spi_miso};
            end else begin
               w_rx_nxt = r_rx;
            end
            if (w_per_end) begin
               w_ph_nxt = 2'd0;
               w_sh_nxt = {r_sh[30:0], 1'b0};
               if (r_bit == 6'd0) begin
                  w_state_nxt     = ACK;
                  w_next_addr_nxt = r_addr + 12'd1;
                  w_next_vld_nxt  = (r_addr != 12'hFFF);
               end else begin
                  w_bit_nxt = r_bit - 6'd1;
               end
            end else begin
               w_ph_nxt = r_ph + 2'd1;
            end
         end
         ACK: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // output logic: next values of the registered SPI pins, acks and read byte
   always_comb begin
      w_done      = (r_state == SHIFT) && (w_state_nxt == ACK);
      w_f_ack_nxt = w_done && !r_port;
      w_d_ack_nxt = w_done && r_port;
      if (w_done) begin
         w_rdata_nxt = r_rx;
      end else begin
         w_rdata_nxt = r_rdata;
      end
      if (w_state_nxt == SHIFT) begin
         w_mosi_nxt = w_sh_nxt[31];
         if (w_fast_nxt) begin
            w_sclk_nxt = (w_ph_nxt == 2'd1);
         end else begin
            w_sclk_nxt = w_ph_nxt[1];
         end
      end else begin
         w_mosi_nxt = 1'b0;
         w_sclk_nxt = 1'b0;
      end
`ifdef SEQ_READ_EN
      case (w_state_nxt)
         SHIFT:   w_cs_n_nxt = 1'b0;
         ACK:     w_cs_n_nxt = 1'b0;
         CSHI:    w_cs_n_nxt = 1'b1;
         IDLE:    w_cs_n_nxt = r_cs_n;
         default: w_cs_n_nxt = 1'b1;
      endcase
`else
      w_cs_n_nxt = (w_state_nxt != SHIFT);
`endif
   end

   // output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cs_n  <= 1'b1;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_f_ack <= 1'b0;
         r_d_ack <= 1'b0;
         r_rdata <= 8'h00;
      end else begin
         r_cs_n  <= w_cs_n_nxt;
         r_sclk  <= w_sclk_nxt;
         r_mosi  <= w_mosi_nxt;
         r_f_ack <= w_f_ack_nxt;
         r_d_ack <= w_d_ack_nxt;
         r_rdata <= w_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Testbench for spi_flash_arbiter: behavioural SPI flash, transaction-level
// reference model, scoreboard queue and an independent monitor.
module tb_spi_flash_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_req = 1'b0;
   logic [11:0] f_addr = 12'h000;
   logic        f_ack;
   logic        d_req = 1'b0;
   logic [11:0] d_addr = 12'h000;
   logic        d_ack;
   logic [7:0]  rdata;
   logic        fast = 1'b1;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso = 1'b0;

`ifdef SEQ_READ_EN
   localparam bit SEQ = 1'b1;
`else
   localparam bit SEQ = 1'b0;
`endif

   spi_flash_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
      .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack),
      .rdata(rdata), .fast(fast),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_q = 1'b0;
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst_n;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input bit ok, input string nm, input longint act, input longint exp);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // flash content
   function automatic logic [7:0] mem(input logic [11:0] a);
      mem = a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
   endfunction

   // ---------------- behavioural SPI flash (mode 0, READ 0x03) --------------
   int          fl_cnt = 0;
   logic [31:0] fl_sr = 32'h0;
   logic [7:0]  fl_cmd = 8'h00;
   logic [23:0] fl_adr = 24'h0;
   logic [11:0] fl_ptr = 12'h000;
   logic [7:0]  fl_byte;
   int          fl_j, fl_k;

   always @(posedge spi_sclk or negedge spi_cs_n) begin
      if (spi_cs_n === 1'b0 && spi_sclk === 1'b0) begin
         fl_cnt = 0;
         fl_cmd = 8'h00;
         fl_adr = 24'h0;
      end else if (spi_cs_n === 1'b0) begin
         if (fl_cnt < 32) begin
            fl_sr = {fl_sr[30:0], spi_mosi};
            if (fl_cnt == 31) begin
               fl_cmd = fl_sr[31:24];
               fl_adr = fl_sr[23:0];
               fl_ptr = fl_sr[11:0];
            end
         end
         fl_cnt = fl_cnt + 1;
      end
   end

   always @(negedge spi_sclk) begin
      if (spi_cs_n === 1'b0 && fl_cnt >= 32) begin
         fl_j     = (fl_cnt - 32) / 8;
         fl_k     = (fl_cnt - 32) % 8;
         fl_byte  = mem(fl_ptr + fl_j[11:0]);
         spi_miso = fl_byte[7 - fl_k];
      end
   end

   // ---------------- reference model + scoreboard ---------------------------
   typedef struct {
      bit          port;
      logic [11:0] addr;
      logic [7:0]  data;
      int          ack_cyc;
      bit          full;
      int          cs_cyc;
   } exp_t;

   exp_t        sb[$];
   bit          m_last = 1'b1;
   logic [11:0] m_next = 12'h000;
   bit          m_vld  = 1'b0;

   task automatic model_grant(input bit port, input logic [11:0] a, input bit f,
                              input int gcyc, output int ackc);
      exp_t e;
      bit   hit;
      hit       = SEQ && m_vld && (a == m_next);
      e.port    = port;
      e.addr    = a;
      e.data    = mem(a);
      e.full    = !hit;
      e.cs_cyc  = f ? 80 : 160;
      if (hit) ackc = gcyc + (f ? 17 : 33);
      else     ackc = gcyc + (f ? 83 : 163);
      e.ack_cyc = ackc;
      sb.push_back(e);
      m_next = a + 12'd1;
      m_vld  = (a != 12'hFFF);
      m_last = port;
   endtask

   // ---------------- monitor ------------------------------------------------
   bit         mon_en = 1'b0;
   logic [7:0] held = 8'h00;
   int         cs_low = 0;

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (!rst_q) begin
            check(spi_cs_n == 1'b1, "rst_cs_n", spi_cs_n, 1);
            check(spi_sclk == 1'b0 && spi_mosi == 1'b0, "rst_sclk_mosi", {spi_sclk, spi_mosi}, 0);
            check(f_ack == 1'b0 && d_ack == 1'b0, "rst_acks", {f_ack, d_ack}, 0);
            check(rdata == 8'h00, "rst_rdata", rdata, 0);
            held   = 8'h00;
            cs_low = 0;
         end else begin
            check(!(f_ack && d_ack), "ack_excl", {f_ack, d_ack}, 0);
            if (spi_cs_n) begin
               check(spi_mosi == 1'b0 && spi_sclk == 1'b0, "idle_pins", {spi_sclk, spi_mosi}, 0);
            end else begin
               cs_low++;
            end
            if (f_ack || d_ack) begin
               if (sb.size() == 0) begin
                  check(1'b0, "unexpected_ack", {f_ack, d_ack}, 0);
               end else begin
                  e = sb.pop_front();
                  check(d_ack == e.port, "ack_port", d_ack, e.port);
                  check(rdata == e.data, "rdata", rdata, e.data);
                  check(cyc == e.ack_cyc, "ack_cycle", cyc, e.ack_cyc);
                  if (e.full) begin
                     check(fl_cmd == 8'h03, "mosi_cmd", fl_cmd, 8'h03);
                     check(fl_adr == {12'h000, e.addr}, "mosi_addr", fl_adr, e.addr);
                  end
                  if (!SEQ) begin
                     check(cs_low == e.cs_cyc, "cs_low_cycles", cs_low, e.cs_cyc);
                  end
               end
               held   = rdata;
               cs_low = 0;
            end else begin
               check(rdata == held, "rdata_hold", rdata, held);
            end
         end
      end
   end

   // ---------------- stimulus ----------------------------------------------
   // called at a sample point (#1 after a rising edge)
   task automatic do_reset(input int ncyc);
      rst_n = 1'b0;
      f_req = 1'b0;
      d_req = 1'b0;
      sb.delete();
      m_last = 1'b1;
      m_vld  = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic do_round(input bit uf, input bit ud, input logic [11:0] fa,
                           input logic [11:0] da, input bit ff, input bit fd, input bit tog);
      bit p0, p1, hold, f1;
      int need, got, ack0, ack1;
      if (uf && ud) p0 = ~m_last;
      else          p0 = ud;
      p1   = ~p0;
      need = (uf && ud) ? 2 : 1;
      f1   = p1 ? fd : ff;
      @(posedge clk); #1;
      model_grant(p0, p0 ? da : fa, p0 ? fd : ff, cyc, ack0);
      if (need == 2) model_grant(p1, p1 ? da : fa, f1, ack0 + 1, ack1);
      fast   = p0 ? fd : ff;
      f_addr = fa;
      d_addr = da;
      f_req  = uf;
      d_req  = ud;
      got    = 0;
      hold   = 1'b0;
      for (int i = 0; i < 1000 && got < need; i++) begin
         @(posedge clk); #1;
         if (f_ack || d_ack) begin
            if (f_ack) f_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            got++;
            if (got < need) begin
               fast = f1;
               hold = 1'b1;
            end
         end else if (hold) begin
            hold = 1'b0;
         end else if (tog) begin
            fast = 1'($urandom_range(0, 1));
         end
      end
      check(got == need, "round_done", got, need);
      f_req = 1'b0;
      d_req = 1'b0;
   endtask

   task automatic do_abort(input logic [11:0] a);
      @(posedge clk); #1;
      fast   = 1'b1;
      f_addr = a;
      f_req  = 1'b1;
      repeat (43) @(posedge clk);
      #1;
      do_reset(1);
      repeat (60) @(posedge clk);
   endtask

   initial begin
      bit          uf, ud, ff, fd, tog;
      int          pat;
      logic [11:0] fa, da;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      do_reset(2);

      do_round(1'b1, 1'b0, 12'h123, 12'h000, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      do_reset(2);
      do_round(1'b1, 1'b1, 12'h200, 12'h300, 1'b1, 1'b0, 1'b0);
      do_round(1'b1, 1'b1, 12'h400, 12'h500, 1'b0, 1'b1, 1'b1);
      do_round(1'b1, 1'b0, 12'h010, 12'h000, 1'b1, 1'b1, 1'b0);
      do_round(1'b1, 1'b0, 12'h011, 12'h000, 1'b1, 1'b1, 1'b0);
      do_round(1'b0, 1'b1, 12'h000, 12'hFFF, 1'b1, 1'b1, 1'b0);
      do_round(1'b0, 1'b1, 12'h000, 12'h000, 1'b1, 1'b1, 1'b0);
      do_round(1'b1, 1'b0, 12'h0AB, 12'h000, 1'b0, 1'b0, 1'b1);
      do_round(1'b1, 1'b0, 12'h0AC, 12'h000, 1'b0, 1'b0, 1'b1);
      do_abort(12'h0C0);
      do_round(1'b1, 1'b0, 12'h0C0, 12'h000, 1'b1, 1'b1, 1'b0);

      for (int r = 0; r < 40; r++) begin
         pat = $urandom_range(0, 2);
         uf  = (pat != 1);
         ud  = (pat != 0);
         fa  = 12'($urandom_range(0, 4095));
         da  = 12'($urandom_range(0, 4095));
         ff  = 1'($urandom_range(0, 1));
         fd  = 1'($urandom_range(0, 1));
         tog = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) fa = 12'hFFF;
         if (m_vld && $urandom_range(0, 1) == 0) fa = m_next;
         if (m_vld && $urandom_range(0, 2) == 0) da = m_next;
         if (uf && ud && $urandom_range(0, 1) == 0) begin
            if (m_last) da = fa + 12'd1;
            else        fa = da + 12'd1;
         end
         do_round(uf, ud, fa, da, ff, fd, tog);
      end

      repeat (5) @(posedge clk);
      check(sb.size() == 0, "sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
